// File: rtl/bcd2binary_seq_if.sv
// Handshake bundle for bcd2binary_seq: BCD source side and binary sink side.
// The converter attaches through the slave modport; the driving logic
// (BCD source plus binary sink) attaches through the master modport.
interface bcd2binary_seq_if #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [BIN_W-1:0]       bin_out;
  logic                   err;

  modport master (
    output in_valid,
    input  in_ready,
    output bcd_in,
    input  out_valid,
    output out_ready,
    input  bin_out,
    input  err
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  bcd_in,
    output out_valid,
    input  out_ready,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One right shift of {digits, result} per clock, then every digit >= 8 has 3
// subtracted. A word takes 4*NDIGITS iterations; input and output each use a
// valid/ready handshake and only one word is in flight at a time.
// Optional macro BCD2BIN_DIGIT_CHECK_EN: reject words holding a digit > 9 by
// raising err with bin_out=0 one clock after acceptance instead of converting.
module bcd2binary_seq #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input logic             clk,
  input logic             reset,
  bcd2binary_seq_if.slave bus
);

  localparam int RW = 4 * NDIGITS;
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] LAST = CW'(RW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } stateType;

  stateType          state;
  stateType          nextState;
  logic [RW-1:0]     digits;
  logic [RW-1:0]     result;
  logic [RW-1:0]     digitsNext;
  logic [RW-1:0]     resultNext;
  logic [CW-1:0]     count;
  logic              accept;
  logic              errFlag;

  // Subtract 3 from every 4-bit digit that is 8 or more, all in parallel.
  function automatic logic [RW-1:0] adjustDigits(input logic [RW-1:0] value);
    logic [RW-1:0] adjusted;
    logic [3:0]    nib;
    adjusted = '0;
    for (int d = 0; d < NDIGITS; d++) begin
      nib = value[4*d +: 4];
      if (nib >= 4'd8) begin
        nib = nib - 4'd3;
      end
      adjusted[4*d +: 4] = nib;
    end
    return adjusted;
  endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic errReg;

  // True when any digit of the word is outside 0..9.
  function automatic logic hasBadDigit(input logic [RW-1:0] value);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (value[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign errFlag = errReg;
  assign bus.err = errReg;
`else
  assign errFlag = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign accept = bus.in_valid && (state == IDLE);

  // One reverse double-dabble step: the digit LSB falls into the result MSB,
  // then the shifted digits are corrected back into valid BCD weights.
  always_comb begin
    resultNext = {digits[0], result[RW-1:1]};
    digitsNext = adjustDigits({1'b0, digits[RW-1:1]});
  end

  // State register; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a rejected word leaves CONV after a single clock
  // without iterating, which keeps the error latency at one clock.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = CONV;
        end
      end
      CONV: begin
        if (errFlag || (count == LAST)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath: capture at acceptance, iterate in CONV, hold in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits <= '0;
      result <= '0;
      count  <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      errReg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            digits <= bus.bcd_in;
            result <= '0;
            count  <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            errReg <= hasBadDigit(bus.bcd_in);
`endif
          end
        end
        CONV: begin
          if (!errFlag) begin
            digits <= digitsNext;
            result <= resultNext;
            count  <= count + CW'(1);
          end
        end
        DONE: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
          if (bus.out_ready) begin
            errReg <= 1'b0;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // The result register is wider than the binary output; its top bits are
  // always zero for valid BCD input and are simply not brought out.
  if (BIN_W <= RW) begin : gNarrowOut
    assign bus.bin_out = result[BIN_W-1:0];
    if (BIN_W < RW) begin : gSpareBits
      logic unusedHigh;
      assign unusedHigh = ^result[RW-1:BIN_W];
    end
  end else begin : gWideOut
    assign bus.bin_out = {{(BIN_W - RW){1'b0}}, result};
  end

endmodule
